// File: rtl/fifo_level_ctr.sv
// Occupancy counter for a DEPTH-entry FIFO with registered empty/full/almost flags.
// Define FIFO_ERR_FLAGS_EN to add sticky OVFERR/UDFERR outputs for illegal strobes.
module fifo_level_ctr #(
  parameter int DEPTH      = 8,
  parameter int CW         = $clog2(DEPTH+1),
  parameter int AEMPTY_LVL = 2,
  parameter int AFULL_LVL  = 6
) (
  input  logic          CLK,
  input  logic          RST_FIFO_,
  input  logic          CLRFIFO,
  input  logic          INCFIFO,
  input  logic          DECFIFO,
  output logic [CW-1:0] FIFOLEVEL,
  output logic          FIFOEMPTY,
  output logic          FIFOFULL,
  output logic          FIFOAEMPTY,
  output logic          FIFOAFULL,
`ifdef FIFO_ERR_FLAGS_EN
  output logic          OVFERR,
  output logic          UDFERR,
`endif
  output logic          INCACCEPT,
  output logic          DECACCEPT
);

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [CW-1:0] AEMPTY_C  = CW'(AEMPTY_LVL);
  localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_LVL);
  localparam logic          AFULL_RST = (AFULL_LVL == 0);

  logic [CW-1:0] level_q, level_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          aempty_q, aempty_d;
  logic          afull_q, afull_d;

  // A write at full is allowed only when a read frees the slot on the same edge.
  assign INCACCEPT = INCFIFO & (~full_q | DECFIFO) & ~CLRFIFO;
  assign DECACCEPT = DECFIFO & ~empty_q & ~CLRFIFO;

  // Flags decode the next level so they land on the same edge as the level.
  always_comb begin
    level_d = level_q;
    if (CLRFIFO)
      level_d = '0;
    else
      level_d = level_q + CW'(INCACCEPT) - CW'(DECACCEPT);
    empty_d  = (level_d == '0);
    full_d   = (level_d == DEPTH_C);
    aempty_d = (level_d <= AEMPTY_C);
    afull_d  = (level_d >= AFULL_C);
  end

  always_ff @(posedge CLK or negedge RST_FIFO_) begin
    if (!RST_FIFO_) begin
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= AFULL_RST;
    end else begin
      level_q  <= level_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
    end
  end

  assign FIFOLEVEL  = level_q;
  assign FIFOEMPTY  = empty_q;
  assign FIFOFULL   = full_q;
  assign FIFOAEMPTY = aempty_q;
  assign FIFOAFULL  = afull_q;

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (INCFIFO & full_q & ~DECFIFO);
    udf_d = udf_q | (DECFIFO & empty_q);
    if (CLRFIFO) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_FIFO_) begin
    if (!RST_FIFO_) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign OVFERR = ovf_q;
  assign UDFERR = udf_q;
`endif

endmodule

// File: tb/tb_fifo_level_ctr.sv
// Directed plus random bench for fifo_level_ctr against a behavioural occupancy model.
module tb_fifo_level_ctr;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH+1);
  localparam int AEL   = 2;
  localparam int AFL   = 6;

  logic          CLK, RST_FIFO_, CLRFIFO, INCFIFO, DECFIFO;
  logic [CW-1:0] FIFOLEVEL;
  logic          FIFOEMPTY, FIFOFULL, FIFOAEMPTY, FIFOAFULL, INCACCEPT, DECACCEPT;
`ifdef FIFO_ERR_FLAGS_EN
  logic          OVFERR, UDFERR;
`endif

  fifo_level_ctr #(.DEPTH(DEPTH), .AEMPTY_LVL(AEL), .AFULL_LVL(AFL)) dut (
    .CLK(CLK), .RST_FIFO_(RST_FIFO_), .CLRFIFO(CLRFIFO), .INCFIFO(INCFIFO),
    .DECFIFO(DECFIFO), .FIFOLEVEL(FIFOLEVEL), .FIFOEMPTY(FIFOEMPTY),
    .FIFOFULL(FIFOFULL), .FIFOAEMPTY(FIFOAEMPTY), .FIFOAFULL(FIFOAFULL),
`ifdef FIFO_ERR_FLAGS_EN
    .OVFERR(OVFERR), .UDFERR(UDFERR),
`endif
    .INCACCEPT(INCACCEPT), .DECACCEPT(DECACCEPT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;
  int lvl   = 0;   // model occupancy
  bit m_ovf = 0;
  bit m_udf = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string ph);
    chk({ph, ".level"},  FIFOLEVEL,  lvl);
    chk({ph, ".empty"},  FIFOEMPTY,  lvl == 0);
    chk({ph, ".full"},   FIFOFULL,   lvl == DEPTH);
    chk({ph, ".aempty"}, FIFOAEMPTY, lvl <= AEL);
    chk({ph, ".afull"},  FIFOAFULL,  lvl >= AFL);
    // redundant flag state must match a decode of the level actually presented
    chk({ph, ".flagdec"}, {FIFOEMPTY, FIFOFULL, FIFOAEMPTY, FIFOAFULL},
        {FIFOLEVEL == 0, FIFOLEVEL == DEPTH, FIFOLEVEL <= AEL, FIFOLEVEL >= AFL});
`ifdef FIFO_ERR_FLAGS_EN
    chk({ph, ".ovferr"}, OVFERR, m_ovf);
    chk({ph, ".udferr"}, UDFERR, m_udf);
`endif
  endtask

  // Called just after a rising edge; drives one cycle and checks both sides of the edge.
  task automatic step(input string ph, input bit inc, input bit dec, input bit clr);
    bit acc_i, acc_d;
    INCFIFO = inc; DECFIFO = dec; CLRFIFO = clr;
    #1;
    acc_i = inc && !clr && (lvl < DEPTH || dec);
    acc_d = dec && !clr && (lvl > 0);
    chk({ph, ".incacc"}, INCACCEPT, acc_i);
    chk({ph, ".decacc"}, DECACCEPT, acc_d);
    @(posedge CLK);
    if (clr) begin
      lvl = 0; m_ovf = 0; m_udf = 0;
    end else begin
      if (inc && lvl == DEPTH && !dec) m_ovf = 1;
      if (dec && lvl == 0) m_udf = 1;
      if (inc && dec)   lvl = (lvl == 0) ? 1 : lvl;
      else if (inc)     lvl = (lvl < DEPTH) ? lvl + 1 : DEPTH;
      else if (dec)     lvl = (lvl > 0) ? lvl - 1 : 0;
    end
    #1;
    chk_outputs(ph);
  endtask

  task automatic model_reset();
    lvl = 0; m_ovf = 0; m_udf = 0;
  endtask

  initial begin
    INCFIFO = 0; DECFIFO = 0; CLRFIFO = 0; RST_FIFO_ = 0;
    #12;
    model_reset();
    chk_outputs("reset");
    chk("reset.afull_lit", FIFOAFULL, 0);
    RST_FIFO_ = 1;

    for (int i = 0; i < 8; i++) step("fill", 1, 0, 0);
    chk("fill.level8", FIFOLEVEL, 8);
    for (int i = 0; i < 2; i++) step("ovf", 1, 0, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf.sticky", OVFERR, 1);
`endif
    for (int i = 0; i < 3; i++) step("full_pass", 1, 1, 0);
    chk("full_pass.full", FIFOFULL, 1);
    for (int i = 0; i < 10; i++) step("drain", 0, 1, 0);
    chk("drain.level0", FIFOLEVEL, 0);
`ifdef FIFO_ERR_FLAGS_EN
    chk("drain.udf", UDFERR, 1);
`endif
    step("empty_both", 1, 1, 0);
    chk("empty_both.level1", FIFOLEVEL, 1);

    while (lvl < 5) step("to5", 1, 0, 0);
    step("clr", 1, 0, 1);
    chk("clr.level0", FIFOLEVEL, 0);

    while (lvl < 4) step("to4", 1, 0, 0);
    #2 RST_FIFO_ = 0;
    #1;
    model_reset();
    chk_outputs("async_rst");
    chk("async_rst.level0", FIFOLEVEL, 0);
    #1 RST_FIFO_ = 1;

    for (int i = 0; i < 400; i++) begin
      automatic int r = $urandom_range(0, 99);
      step("rand", r < 55 ? 1'b1 : 1'b0, ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
           (r % 37) == 0 ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
